mdu: RTL and testbench
======================

Name: mdu

Overview:
Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle combinational ALU. It takes the same A/B operand buses, runs mult/multu/div/divu over several clocks, and holds results in the HI/LO registers. It raises Busy so hazard control can stall later mult/div, mfhi/mflo, mthi and mtlo instructions. The ALU completes in one cycle; this block is its sequential, handshaked counterpart.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (must be >= 1).
DIV_CYCLES, 10, Busy cycles for div/divu (must be >= 1).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
A  input  32  operand rs; also the mthi/mtlo data.
B  input  32  operand rt.
MDOp  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
Start  input  1  one-cycle pulse that launches MDOp on A/B.
HIWrite  input  1  mthi: HI <= A.
LOWrite  input  1  mtlo: LO <= A.
HISel  input  1  read select: 1 selects HI, 0 selects LO.
Busy  output  1  operation in flight.
Out  output  32  HISel ? HI : LO, combinational from the registers.

Behaviour:
- Reset, asynchronous: HI=0, LO=0, count=0, Busy=0, and Out=0 follows. Reset mid-operation aborts the operation and discards its result.
- Two states, IDLE and RUN. The down-counter is sized to the larger parameter.
- IDLE with Start=1:
  - latch A, B and MDOp.
  - load count = MULT_CYCLES or DIV_CYCLES.
  - go to RUN, so Busy=1 from the next edge.
- RUN, each edge: count--. On the edge where count reaches 0:
  - write HI/LO.
  - go to IDLE, so Busy=0 in the same cycle the new HI/LO become visible.
  - Total latency from the Start edge to results visible is exactly N cycles, with Busy high for N cycles.
- Start while Busy: ignored. Control must stall instead.
- HIWrite/LOWrite while Busy: ignored.
- HIWrite/LOWrite and Start in the same IDLE cycle: Start wins and the writes are dropped. Control never issues both together.
- HIWrite and LOWrite together: both registers are written.
- mult: signed 32x32 to 64-bit product; HI = product[63:32], LO = product[31:0].
- multu: the same, unsigned.
- div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (B=0 on div/divu): full DIV_CYCLES latency; HI and LO are left unchanged.
- The result is computed from the operands latched at Start; changes on A/B during RUN have no effect.
- Out reflects HI/LO only; it never shows intermediate values.

Decomposition:
- Shared package/header holds the MDOp codes (MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11) and the state encodings (ST_IDLE, ST_RUN).
- The control decoder and hazard unit import the same MDOp codes.
- One sub-module is natural: mdu_calc, a combinational 64-bit result generator from latched A, B and MDOp, with a div-by-zero flag. mdu keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset: assert reset mid-mult (A=3, B=4, 2 cycles in) -> Busy=0 and HI=LO=0 immediately; no write after reset is released.
- mult, A=0xFFFFFFFF (-1), B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div, A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu, A=7, B=2 -> LO=3, HI=1.
- div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero, HI=0x11, LO=0x22 preset via mthi/mtlo, then div with B=0 -> Busy for 10 cycles, HI/LO still 0x11/0x22.
- Start (A=5, B=6, mult), then pulse Start with A=1, B=1 and HIWrite with A=0xAA during Busy -> both ignored; final HI=0, LO=30; HISel toggles Out between 0 and 30.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp codes, FSM states and
// a small decode helper reused by control and hazard logic.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {HI, LO} result generator for the latched operands,
// plus a divide-by-zero flag so the caller can leave HI/LO untouched.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sdiv;
  logic signed [31:0] squot;
  logic signed [31:0] srem;
  logic        [31:0] udiv;
  logic               div_ovf;

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // MIN/-1 is steered to MIN/1, which yields the architecturally wrapped
  // quotient 0x80000000 and remainder 0 without an overflowing divide.
  assign sdiv  = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
  assign udiv  = div_zero ? 32'd1 : b;
  assign squot = $signed(a) / sdiv;
  assign srem  = $signed(a) % sdiv;

  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = prod_s;
    case (op)
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {srem, squot};
      MD_DIVU:  result = {a % udiv, a / udiv};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a Busy flag that
// hazard control uses to stall dependent mult/div and HI/LO accesses.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  MDOp,
  input  logic        Start,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HISel,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   state;
  logic [CW-1:0] count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] a_q;
  logic [31:0] b_q;
  md_op_e      op_q;
  logic [63:0] result;
  logic        div_zero;

  mdu_calc u_calc (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (result),
    .div_zero (div_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= md_op_e'(MDOp);
            count <= is_div(md_op_e'(MDOp)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state <= ST_RUN;
          end else begin
            if (HIWrite) hi <= A;
            if (LOWrite) lo <= A;
          end
        end
        ST_RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ST_IDLE;
            if (!(is_div(op_q) && div_zero)) begin
              hi <= result[63:32];
              lo <= result[31:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state == ST_RUN);
  assign Out  = HISel ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases followed by random
// operations compared against a plain-arithmetic HI/LO model.
module tb_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [1:0]  MDOp;
  logic        Start, HIWrite, LOWrite, HISel;
  logic        Busy;
  logic [31:0] Out;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .MDOp    (MDOp),
    .Start   (Start),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite),
    .HISel   (HISel),
    .Busy    (Busy),
    .Out     (Out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    HISel = 1'b1;
    #1 check({tag, " HI"}, Out, m_hi);
    HISel = 1'b0;
    #1 check({tag, " LO"}, Out, m_lo);
  endtask

  // Reference: 64-bit arithmetic straight from the operation definitions.
  function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      2'b00: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      2'b10: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
    endcase
  endfunction

  task automatic wait_idle(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (Busy === 1'b1 && cyc < n + 20) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(cyc), 32'(n));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; MDOp = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    HISel = 1'b0;
    #1 check({tag, " LO held while busy"}, Out, m_lo);
    wait_idle(tag, op[1] ? DIV_CYCLES : MULT_CYCLES);
    model_op(op, a, b);
    check_regs(tag);
  endtask

  task automatic write_hilo(input logic hiw, input logic low, input logic [31:0] val);
    @(negedge clk);
    A = val; HIWrite = hiw; LOWrite = low;
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    if (hiw) m_hi = val;
    if (low) m_lo = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; A = '0; B = '0; MDOp = '0;
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; HISel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, Busy}, 32'd0);
    check_regs("reset");
    reset = 1'b0;

    // Abort a mult two cycles in; preset HI/LO so the clear is visible.
    write_hilo(1'b1, 1'b1, 32'h55);
    check_regs("preset");
    @(negedge clk);
    A = 32'd3; B = 32'd4; MDOp = 2'b00; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    #1 check("abort busy", {31'd0, Busy}, 32'd0);
    check_regs("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post-abort busy", {31'd0, Busy}, 32'd0);
    check_regs("post-abort");

    run_op("mult -1*2",   2'b00, 32'hFFFF_FFFF, 32'd2);
    run_op("multu -1*2",  2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu 7/2",    2'b11, 32'd7, 32'd2);
    run_op("div min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    write_hilo(1'b1, 1'b0, 32'h11);
    write_hilo(1'b0, 1'b1, 32'h22);
    run_op("div by zero", 2'b10, 32'd9, 32'd0);
    run_op("divu by zero", 2'b11, 32'd9, 32'd0);

    // Start and mthi/mtlo while busy must be ignored.
    @(negedge clk);
    A = 32'd5; B = 32'd6; MDOp = 2'b00; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    A = 32'd1; B = 32'd1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = 32'hAA; HIWrite = 1'b1; LOWrite = 1'b1;
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    wait_idle("busy-ignore", MULT_CYCLES - 3);
    m_hi = 32'd0; m_lo = 32'd30;
    check_regs("busy-ignore");
    repeat (3) @(negedge clk);
    check("no relaunch", {31'd0, Busy}, 32'd0);

    write_hilo(1'b1, 1'b1, 32'h1234);
    check_regs("mthi+mtlo");

    // Start wins over same-cycle writes; div by zero keeps HI/LO visible.
    @(negedge clk);
    A = 32'h99; B = 32'd0; MDOp = 2'b10; Start = 1'b1; HIWrite = 1'b1; LOWrite = 1'b1;
    @(negedge clk);
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    wait_idle("start-wins", DIV_CYCLES);
    check_regs("start-wins");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
